// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR and its byte-stream consumer.
//   LFSR_W / BYTE_W   : LFSR state width and stream byte width
//   LFSR_SEED         : power-on seed used by the companion LFSR
//   streamer_state_e  : FSM encoding for lfsr_byte_streamer
package lfsr_pkg;

    localparam int unsigned LFSR_W    = 32;
    localparam int unsigned BYTE_W    = 8;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 32'h00BAD1C4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } streamer_state_e;

endpackage : lfsr_pkg

// File: rtl/lfsr_byte_streamer.sv
// lfsr_byte_streamer
// Emits a burst of len_i pseudo-random bytes on a valid/ready byte stream.
// The LFSR state word is sampled once per 4 bytes and sent MSB-first.
//
// Ports:
//   clk_i        : clock, rising edge
//   reset_ni     : asynchronous active-low reset
//   start_i      : burst request, only honoured in IDLE
//   len_i        : burst length in bytes, sampled with start_i
//   lfsr_state_i : free-running LFSR state
//   data_o       : current byte (0 when not valid)
//   valid_o      : data_o is valid
//   ready_i      : sink accepts the byte
//   busy_o       : burst in progress (SEND or DONE)
//   done_o       : one-cycle pulse at burst completion
//   remaining_o  : bytes still to be transferred
module lfsr_byte_streamer
    import lfsr_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [LFSR_W-1:0] lfsr_state_i,
    output logic [BYTE_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [LEN_W-1:0]  remaining_o
);

    streamer_state_e   r_state, w_state_next;
    logic [LFSR_W-1:0] r_word, w_word_next;
    logic [1:0]        r_idx, w_idx_next;
    logic [LEN_W-1:0]  r_remaining, w_remaining_next;

    // Byte lanes of the captured word; lane 0 is the most significant byte.
    logic [BYTE_W-1:0] w_bytes [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lanes
            assign w_bytes[gi] = r_word[LFSR_W-1-BYTE_W*gi -: BYTE_W];
        end
    endgenerate

    // Registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state     <= IDLE;
            r_word      <= '0;
            r_idx       <= '0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_next;
            r_word      <= w_word_next;
            r_idx       <= w_idx_next;
            r_remaining <= w_remaining_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next     = r_state;
        w_word_next      = r_word;
        w_idx_next       = r_idx;
        w_remaining_next = r_remaining;

        unique case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_remaining_next = len_i;
                    if (len_i == '0) begin
                        w_state_next = DONE;
                    end else begin
                        w_word_next  = lfsr_state_i;
                        w_idx_next   = '0;
                        w_state_next = SEND;
                    end
                end
            end
            SEND: begin
                // Guarded decrement keeps remaining from wrapping.
                if (ready_i && (r_remaining != '0)) begin
                    w_remaining_next = r_remaining - LEN_W'(1);
                    if (r_remaining == LEN_W'(1)) begin
                        w_state_next = DONE;
                    end else if (r_idx == 2'd3) begin
                        // Refresh the word on the last lane's handshake so
                        // the next byte follows with no bubble.
                        w_word_next = lfsr_state_i;
                        w_idx_next  = '0;
                    end else begin
                        w_idx_next = r_idx + 2'd1;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Outputs decode from registers only, so valid_o is independent of ready_i.
    always_comb begin
        valid_o     = (r_state == SEND);
        data_o      = valid_o ? w_bytes[r_idx] : '0;
        busy_o      = (r_state != IDLE);
        done_o      = (r_state == DONE);
        remaining_o = r_remaining;
    end

endmodule : lfsr_byte_streamer

// File: tb/tb_lfsr_byte_streamer.sv
// Directed testbench for lfsr_byte_streamer.
module tb_lfsr_byte_streamer;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        start_i;
    logic [7:0]  len_i;
    logic [31:0] lfsr_state_i;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i;
    logic        busy_o;
    logic        done_o;
    logic [7:0]  remaining_o;

    int n_checks = 0;
    int n_fail   = 0;

    lfsr_byte_streamer #(.LEN_W(8)) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .start_i      (start_i),
        .len_i        (len_i),
        .lfsr_state_i (lfsr_state_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .remaining_o  (remaining_o)
    );

    always #5 clk_i = ~clk_i;

    // One line per accepted byte.
    always @(posedge clk_i) begin
        if (valid_o && ready_i)
            $display("xfer: byte=%02h remaining_before=%0d", data_o, remaining_o);
    end

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_ni = 1'b0; start_i = 1'b0; len_i = '0; ready_i = 1'b1;
        lfsr_state_i = 32'h00BAD1C4;
        #3;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        n_checks++; if (data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%02h exp=00", data_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done_o); end
        n_checks++; if (remaining_o !== 8'd0) begin n_fail++; $display("FAIL reset_remaining got=%0d exp=0", remaining_o); end
        @(posedge clk_i); #1;
        reset_ni = 1'b1;
        step();
    endtask

    task automatic test_first_word();
        logic [7:0] exp_b [4] = '{8'h00, 8'hBA, 8'hD1, 8'hC4};
        lfsr_state_i = 32'h00BAD1C4; len_i = 8'd4; ready_i = 1'b1; start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL first_valid[%0d] got=%b exp=1", i, valid_o); end
            n_checks++; if (data_o !== exp_b[i]) begin n_fail++; $display("FAIL first_data[%0d] got=%02h exp=%02h", i, data_o, exp_b[i]); end
            step();
        end
        n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL first_done got=%b exp=1", done_o); end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL first_valid_at_done got=%b exp=0", valid_o); end
        step();
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL first_busy_after got=%b exp=0", busy_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL first_done_pulse got=%b exp=0", done_o); end
        n_checks++; if (remaining_o !== 8'd0) begin n_fail++; $display("FAIL first_remaining_idle got=%0d exp=0", remaining_o); end
    endtask

    task automatic test_word_refresh();
        logic [7:0] exp_b [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};
        lfsr_state_i = 32'h11223344; len_i = 8'd6; ready_i = 1'b1; start_i = 1'b1;
        step();
        start_i = 1'b0;
        lfsr_state_i = 32'hDEADBEEF;   // must not be picked up mid-word
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (data_o !== exp_b[i] || valid_o !== 1'b1) begin n_fail++; $display("FAIL refresh_data[%0d] got=%02h/v%b exp=%02h/v1", i, data_o, valid_o, exp_b[i]); end
            lfsr_state_i = (i == 3) ? 32'hAABBCCDD : 32'h12345678;
            step();
        end
        n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL refresh_done got=%b exp=1", done_o); end
        step();
    endtask

    task automatic test_backpressure();
        logic       rdy [5]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] exp_b [5] = '{8'hCA, 8'hFE, 8'hFE, 8'hFE, 8'hF0};
        logic [7:0] exp_r [5] = '{8'd3, 8'd2, 8'd2, 8'd2, 8'd1};
        int hs = 0;
        lfsr_state_i = 32'hCAFEF00D; len_i = 8'd3; ready_i = 1'b1; start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            lfsr_state_i = 32'h0F0F0F0F ^ i;
            ready_i = rdy[i];
            n_checks++; if (data_o !== exp_b[i] || valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_data[%0d] got=%02h/v%b exp=%02h/v1", i, data_o, valid_o, exp_b[i]); end
            n_checks++; if (remaining_o !== exp_r[i]) begin n_fail++; $display("FAIL bp_remaining[%0d] got=%0d exp=%0d", i, remaining_o, exp_r[i]); end
            if (valid_o && ready_i) hs++;
            step();
        end
        ready_i = 1'b1;
        n_checks++; if (hs !== 3) begin n_fail++; $display("FAIL bp_handshakes got=%0d exp=3", hs); end
        n_checks++; if (done_o !== 1'b1 || valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_done got=%b/v%b exp=1/v0", done_o, valid_o); end
        step();
    endtask

    task automatic test_zero_len();
        len_i = 8'd0; start_i = 1'b1;
        step();
        start_i = 1'b0;
        n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL zero_done got=%b exp=1", done_o); end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL zero_valid got=%b exp=0", valid_o); end
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL zero_busy got=%b exp=1", busy_o); end
        step();
        n_checks++; if (done_o !== 1'b0 || busy_o !== 1'b0 || valid_o !== 1'b0) begin n_fail++; $display("FAIL zero_idle got=d%b/b%b/v%b exp=d0/b0/v0", done_o, busy_o, valid_o); end
    endtask

    task automatic test_start_ignored();
        lfsr_state_i = 32'h01020304; len_i = 8'd2; start_i = 1'b1;
        step();
        len_i = 8'd1;   // only seen once back in IDLE
        lfsr_state_i = 32'h0A0B0C0D;
        n_checks++; if (data_o !== 8'h01) begin n_fail++; $display("FAIL ign_byte0 got=%02h exp=01", data_o); end
        step();
        n_checks++; if (data_o !== 8'h02 || remaining_o !== 8'd1) begin n_fail++; $display("FAIL ign_byte1 got=%02h/r%0d exp=02/r1", data_o, remaining_o); end
        step();
        n_checks++; if (done_o !== 1'b1 || valid_o !== 1'b0) begin n_fail++; $display("FAIL ign_done got=%b/v%b exp=1/v0", done_o, valid_o); end
        step();
        n_checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin n_fail++; $display("FAIL ign_idle got=b%b/d%b exp=b0/d0", busy_o, done_o); end
        step();
        start_i = 1'b0;
        n_checks++; if (valid_o !== 1'b1 || data_o !== 8'h0A || remaining_o !== 8'd1) begin n_fail++; $display("FAIL ign_restart got=v%b/%02h/r%0d exp=v1/0A/r1", valid_o, data_o, remaining_o); end
        step();
        n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL ign_restart_done got=%b exp=1", done_o); end
        step();
    endtask

    task automatic test_mid_reset();
        int done_seen = 0;
        lfsr_state_i = 32'h13579BDF; len_i = 8'd8; ready_i = 1'b1; start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        step();
        n_checks++; if (data_o !== 8'h9B || remaining_o !== 8'd6) begin n_fail++; $display("FAIL mid_pre got=%02h/r%0d exp=9B/r6", data_o, remaining_o); end
        #2 reset_ni = 1'b0;
        #1;
        n_checks++; if (valid_o !== 1'b0 || data_o !== 8'h00 || busy_o !== 1'b0 || done_o !== 1'b0) begin n_fail++; $display("FAIL mid_abort got=v%b/%02h/b%b/d%b exp=v0/00/b0/d0", valid_o, data_o, busy_o, done_o); end
        n_checks++; if (remaining_o !== 8'd0) begin n_fail++; $display("FAIL mid_remaining got=%0d exp=0", remaining_o); end
        step();
        reset_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done_o !== 1'b0 || busy_o !== 1'b0) done_seen++;
        end
        n_checks++; if (done_seen !== 0) begin n_fail++; $display("FAIL mid_no_done got=%0d exp=0", done_seen); end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_word_refresh();
        test_backpressure();
        test_zero_len();
        test_start_ignored();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_lfsr_byte_streamer
